// File: rtl/biu_constants_pkg.sv
// biu_constants_pkg: BIU transfer size, burst type and protection encodings
package biu_constants_pkg;
  typedef enum logic [2:0] {BYTE = 3'd0, HWORD = 3'd1, WORD = 3'd2, DWORD = 3'd3} biu_size_t;
  typedef enum logic [1:0] {SINGLE = 2'd0, INCR = 2'd1, WRAP = 2'd2} biu_type_t;
  typedef logic [2:0] biu_prot_t;
  localparam biu_prot_t PROT_DATA  = 3'b001;
  localparam biu_prot_t PROT_PRIV  = 3'b010;
  localparam biu_prot_t PROT_CACHE = 3'b100;
endpackage

// File: rtl/riscv_cache_pkg.sv
// riscv_cache_pkg: cache-subsystem arbiter state and owner encodings
package riscv_cache_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, LOCKED} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_I = 2'b01, OWN_D = 2'b10} arb_owner_t;
endpackage

// File: rtl/riscv_rr_arb2.sv
// riscv_rr_arb2: 2-way round-robin grant with last-owner register
//   req[1:0] : {D,I} requests (already masked by the caller)
//   gnt[1:0] : one-hot {D,I} grant, combinational from req
module riscv_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_d;
  // on a tie the master that did not win last time is granted; reset favours D
  assign gnt = &req ? (last_d ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_d <= 1'b0;
    else if (|gnt) last_d <= gnt[1];
endmodule

// File: rtl/riscv_cache_biu_arb.sv
// riscv_cache_biu_arb: shares one BIU between the I-cache and D-cache memory FSMs
//   i_*/d_*  : master request attributes in, stb_ack/ack/err/q back to the owner
//   biu_*    : registered request to the BIU, stb_ack/ack/err/q responses from it
//   owner_o  : one-hot {D,I} current owner, busy_o : arbiter not idle
module riscv_cache_biu_arb
  import biu_constants_pkg::*, riscv_cache_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PLEN      = XLEN == 32 ? 34 : 56,
  parameter int BURST_LEN = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            i_req_i,
  input  logic [PLEN-1:0] i_adr_i,
  input  biu_size_t       i_size_i,
  input  biu_type_t       i_type_i,
  input  logic            i_we_i,
  input  logic [XLEN-1:0] i_d_i,
  input  biu_prot_t       i_prot_i,
  input  logic            i_lock_i,
  output logic            i_stb_ack_o,
  output logic            i_ack_o,
  output logic            i_err_o,
  output logic [XLEN-1:0] i_q_o,
  input  logic            d_req_i,
  input  logic [PLEN-1:0] d_adr_i,
  input  biu_size_t       d_size_i,
  input  biu_type_t       d_type_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_d_i,
  input  biu_prot_t       d_prot_i,
  input  logic            d_lock_i,
  output logic            d_stb_ack_o,
  output logic            d_ack_o,
  output logic            d_err_o,
  output logic [XLEN-1:0] d_q_o,
  output logic            biu_stb_o,
  output logic [PLEN-1:0] biu_adr_o,
  output biu_size_t       biu_size_o,
  output biu_type_t       biu_type_o,
  output logic            biu_we_o,
  output logic [XLEN-1:0] biu_d_o,
  output biu_prot_t       biu_prot_o,
  output logic            biu_lock_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i,
  input  logic [XLEN-1:0] biu_q_i,
  output logic [1:0]      owner_o,
  output logic            busy_o
);
  localparam int CW = $clog2(BURST_LEN + 1);
  arb_state_t      state, state_nxt;
  arb_owner_t      owner;
  logic [PLEN-1:0] adr;
  biu_size_t       size;
  biu_type_t       typ;
  logic            we;
  logic [XLEN-1:0] dat;
  biu_prot_t       prot;
  logic            lock;
  logic [CW-1:0]   cnt;
  logic [1:0]      req, gnt;
  logic            act, own_i, own_d, own_lock, sel_d, done;
  assign act      = state == ADDR || state == DATA;
  assign own_i    = owner == OWN_I;
  assign own_d    = owner == OWN_D;
  assign own_lock = own_d ? d_lock_i : i_lock_i;
  assign sel_d    = gnt[1];
  assign done     = act && biu_ack_i && cnt == CW'(1);
  // while locked only the current owner may start a new transaction
  assign req = state == IDLE   ? {d_req_i, i_req_i} :
               state == LOCKED ? {d_req_i & own_d, i_req_i & own_i} : 2'b00;
  riscv_rr_arb2 u_rr (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .req   (req),
    .gnt   (gnt)
  );
  always_comb begin
    state_nxt = state;
    if (|gnt) state_nxt = ADDR;
    else if (act && biu_err_i) state_nxt = IDLE;
    else if (done) state_nxt = lock && own_lock ? LOCKED : IDLE;
    else if (state == ADDR && biu_stb_ack_i) state_nxt = DATA;
    else if (state == LOCKED && !own_lock) state_nxt = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      owner <= OWN_NONE;
      adr   <= '0;
      size  <= BYTE;
      typ   <= SINGLE;
      we    <= 1'b0;
      dat   <= '0;
      prot  <= '0;
      lock  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= state_nxt == IDLE ? OWN_NONE : |gnt ? arb_owner_t'(gnt) : owner;
      if (|gnt) begin
        adr  <= sel_d ? d_adr_i : i_adr_i;
        size <= sel_d ? d_size_i : i_size_i;
        typ  <= sel_d ? d_type_i : i_type_i;
        we   <= sel_d ? d_we_i : i_we_i;
        dat  <= sel_d ? d_d_i : i_d_i;
        prot <= sel_d ? d_prot_i : i_prot_i;
        lock <= sel_d ? d_lock_i : i_lock_i;
        cnt  <= (sel_d ? d_type_i : i_type_i) == SINGLE ? CW'(1) : CW'(BURST_LEN);
      end else if (act && biu_err_i) cnt <= '0;
      else if (act && biu_ack_i && cnt != '0) cnt <= cnt - CW'(1);
    end
  assign i_stb_ack_o = state == ADDR && own_i && biu_stb_ack_i;
  assign d_stb_ack_o = state == ADDR && own_d && biu_stb_ack_i;
  assign i_ack_o     = act && own_i && biu_ack_i;
  assign d_ack_o     = act && own_d && biu_ack_i;
  assign i_err_o     = act && own_i && biu_err_i;
  assign d_err_o     = act && own_d && biu_err_i;
  assign i_q_o       = biu_q_i;
  assign d_q_o       = biu_q_i;
  assign biu_stb_o   = state == ADDR;
  assign biu_adr_o   = adr;
  assign biu_size_o  = size;
  assign biu_type_o  = typ;
  assign biu_we_o    = we;
  assign biu_d_o     = dat;
  assign biu_prot_o  = prot;
  assign biu_lock_o  = lock;
  assign owner_o     = owner;
  assign busy_o      = state != IDLE;
endmodule

// File: tb/tb_riscv_cache_biu_arb.sv
// tb_riscv_cache_biu_arb: directed, table-driven and randomized checks of the I/D BIU arbiter
module tb_riscv_cache_biu_arb;
  import biu_constants_pkg::*;
  localparam int XLEN = 32;
  localparam int PLEN = 34;
  localparam int BL   = 4;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;
  logic            i_req_i, d_req_i, i_we_i, d_we_i, i_lock_i, d_lock_i;
  logic [PLEN-1:0] i_adr_i, d_adr_i;
  biu_size_t       i_size_i, d_size_i;
  biu_type_t       i_type_i, d_type_i;
  logic [XLEN-1:0] i_d_i, d_d_i;
  biu_prot_t       i_prot_i, d_prot_i;
  logic            i_stb_ack_o, i_ack_o, i_err_o, d_stb_ack_o, d_ack_o, d_err_o;
  logic [XLEN-1:0] i_q_o, d_q_o;
  logic            biu_stb_o, biu_we_o, biu_lock_o;
  logic [PLEN-1:0] biu_adr_o;
  biu_size_t       biu_size_o;
  biu_type_t       biu_type_o;
  logic [XLEN-1:0] biu_d_o;
  biu_prot_t       biu_prot_o;
  logic            biu_stb_ack_i, biu_ack_i, biu_err_i;
  logic [XLEN-1:0] biu_q_i;
  logic [1:0]      owner_o;
  logic            busy_o;
  riscv_cache_biu_arb #(.XLEN(XLEN), .PLEN(PLEN), .BURST_LEN(BL)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .i_req_i(i_req_i), .i_adr_i(i_adr_i), .i_size_i(i_size_i), .i_type_i(i_type_i),
    .i_we_i(i_we_i), .i_d_i(i_d_i), .i_prot_i(i_prot_i), .i_lock_i(i_lock_i),
    .i_stb_ack_o(i_stb_ack_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_q_o(i_q_o),
    .d_req_i(d_req_i), .d_adr_i(d_adr_i), .d_size_i(d_size_i), .d_type_i(d_type_i),
    .d_we_i(d_we_i), .d_d_i(d_d_i), .d_prot_i(d_prot_i), .d_lock_i(d_lock_i),
    .d_stb_ack_o(d_stb_ack_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_q_o(d_q_o),
    .biu_stb_o(biu_stb_o), .biu_adr_o(biu_adr_o), .biu_size_o(biu_size_o),
    .biu_type_o(biu_type_o), .biu_we_o(biu_we_o), .biu_d_o(biu_d_o),
    .biu_prot_o(biu_prot_o), .biu_lock_o(biu_lock_o),
    .biu_stb_ack_i(biu_stb_ack_i), .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i),
    .biu_q_i(biu_q_i), .owner_o(owner_o), .busy_o(busy_o)
  );
  int cmp = 0, bad = 0;
  int n_isa, n_dsa, n_ia, n_da, n_ie, n_de;
  typedef struct {
    logic            i_req;
    logic            d_req;
    biu_type_t       i_ty;
    biu_type_t       d_ty;
    logic [1:0]      exp_own;
    int              exp_beats;
    logic [PLEN-1:0] exp_adr;
  } vec_t;
  vec_t tv[8];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr_cnt;
    n_isa = 0; n_dsa = 0; n_ia = 0; n_da = 0; n_ie = 0; n_de = 0;
  endtask
  // one BIU response cycle; a master releases its request once its address phase is accepted
  task automatic cyc(input logic sa, input logic a, input logic e);
    logic drop_i, drop_d;
    biu_stb_ack_i = sa; biu_ack_i = a; biu_err_i = e;
    #1;
    if (i_stb_ack_o) n_isa++;
    if (d_stb_ack_o) n_dsa++;
    if (i_ack_o) n_ia++;
    if (d_ack_o) n_da++;
    if (i_err_o) n_ie++;
    if (d_err_o) n_de++;
    drop_i = i_stb_ack_o;
    drop_d = d_stb_ack_o;
    @(posedge clk);
    #1;
    biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0; biu_err_i = 1'b0;
    if (drop_i) i_req_i = 1'b0;
    if (drop_d) d_req_i = 1'b0;
  endtask
  task automatic set_i(input logic [PLEN-1:0] a, input biu_type_t t, input logic we, input logic lk);
    i_req_i = 1'b1; i_adr_i = a; i_type_i = t; i_we_i = we; i_lock_i = lk;
    i_size_i = WORD; i_prot_i = 3'b101; i_d_i = $urandom;
  endtask
  task automatic set_d(input logic [PLEN-1:0] a, input biu_type_t t, input logic we, input logic lk);
    d_req_i = 1'b1; d_adr_i = a; d_type_i = t; d_we_i = we; d_lock_i = lk;
    d_size_i = WORD; d_prot_i = 3'b011; d_d_i = $urandom;
  endtask
  task automatic do_reset;
    rst_ni = 1'b0;
    i_req_i = 1'b0; d_req_i = 1'b0; i_lock_i = 1'b0; d_lock_i = 1'b0;
    i_we_i = 1'b0; d_we_i = 1'b0; i_adr_i = '0; d_adr_i = '0;
    i_size_i = BYTE; d_size_i = BYTE; i_type_i = SINGLE; d_type_i = SINGLE;
    i_d_i = '0; d_d_i = '0; i_prot_i = '0; d_prot_i = '0;
    biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0; biu_err_i = 1'b0; biu_q_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask
  // address-phase acceptance after a random wait, then the data beats with random gaps
  task automatic serve(input int beats, input int err_at);
    int b;
    bit co;
    clr_cnt();
    repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0);
    co = $urandom_range(0, 1) == 1;
    cyc(1'b1, co, 1'b0);
    b = co ? 2 : 1;
    while (b <= beats) begin
      repeat ($urandom_range(0, 1)) cyc(1'b0, 1'b0, 1'b0);
      if (b == err_at) begin
        cyc(1'b0, 1'b0, 1'b1);
        b = beats + 1;
      end else begin
        cyc(1'b0, 1'b1, 1'b0);
        b++;
      end
    end
  endtask
  task automatic post_chk(input string nm, input bit w, input int acks, input int errs);
    chk({nm, "_stb_ack"}, 64'(w ? n_dsa : n_isa), 64'(1));
    chk({nm, "_own_acks"}, 64'(w ? n_da : n_ia), 64'(acks));
    chk({nm, "_other_acks"}, 64'(w ? n_ia : n_da), 64'(0));
    chk({nm, "_own_err"}, 64'(w ? n_de : n_ie), 64'(errs));
    chk({nm, "_idle_after"}, 64'(busy_o), 64'(0));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bit w, last_d;
    int beats, err_at, r;
    logic [PLEN-1:0] ea;
    logic [XLEN-1:0] ed;
    logic ewe;
    biu_type_t ety;
    tv[0] = '{1'b1, 1'b1, SINGLE, SINGLE, 2'b10, 1, 34'h2000};
    tv[1] = '{1'b1, 1'b1, INCR,   SINGLE, 2'b01, 4, 34'h1010};
    tv[2] = '{1'b1, 1'b1, SINGLE, WRAP,   2'b10, 4, 34'h2020};
    tv[3] = '{1'b0, 1'b1, SINGLE, SINGLE, 2'b10, 1, 34'h2030};
    tv[4] = '{1'b1, 1'b1, SINGLE, INCR,   2'b01, 1, 34'h1040};
    tv[5] = '{1'b1, 1'b0, WRAP,   SINGLE, 2'b01, 4, 34'h1050};
    tv[6] = '{1'b1, 1'b1, INCR,   SINGLE, 2'b10, 1, 34'h2060};
    tv[7] = '{1'b1, 1'b0, SINGLE, SINGLE, 2'b01, 1, 34'h1070};
    do_reset();
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_owner", 64'(owner_o), 64'(0));
    chk("rst_stb", 64'(biu_stb_o), 64'(0));
    chk("rst_adr", 64'(biu_adr_o), 64'(0));
    // I single read
    set_i(34'h100, SINGLE, 1'b0, 1'b0);
    #1;
    chk("t1_no_comb_stb", 64'(biu_stb_o), 64'(0));
    tick();
    chk("t1_stb", 64'(biu_stb_o), 64'(1));
    chk("t1_owner", 64'(owner_o), 64'(2'b01));
    chk("t1_adr", 64'(biu_adr_o), 64'(34'h100));
    chk("t1_size", 64'(biu_size_o), 64'(WORD));
    chk("t1_prot", 64'(biu_prot_o), 64'(3'b101));
    biu_q_i = 32'hCAFE_F00D;
    #1;
    chk("t1_i_q", 64'(i_q_o), 64'(32'hCAFE_F00D));
    chk("t1_d_q", 64'(d_q_o), 64'(32'hCAFE_F00D));
    clr_cnt();
    cyc(1'b1, 1'b1, 1'b0);
    chk("t1_i_stb_ack", 64'(n_isa), 64'(1));
    chk("t1_i_ack", 64'(n_ia), 64'(1));
    chk("t1_d_ack", 64'(n_da), 64'(0));
    chk("t1_idle", 64'(busy_o), 64'(0));
    chk("t1_owner_idle", 64'(owner_o), 64'(0));
    // simultaneous requests right after reset: D first, I after one idle cycle
    do_reset();
    set_i(34'h200, SINGLE, 1'b0, 1'b0);
    set_d(34'h300, SINGLE, 1'b0, 1'b0);
    tick();
    chk("t2_owner_d", 64'(owner_o), 64'(2'b10));
    chk("t2_adr_d", 64'(biu_adr_o), 64'(34'h300));
    clr_cnt();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t2_d_ack", 64'(n_da), 64'(1));
    chk("t2_idle_gap", 64'(biu_stb_o), 64'(0));
    tick();
    chk("t2_stb_i", 64'(biu_stb_o), 64'(1));
    chk("t2_owner_i", 64'(owner_o), 64'(2'b01));
    chk("t2_adr_i", 64'(biu_adr_o), 64'(34'h200));
    cyc(1'b1, 1'b1, 1'b0);
    // D burst: four acks, then a spurious ack in IDLE
    set_d(34'h800, INCR, 1'b0, 1'b0);
    tick();
    chk("t3_owner", 64'(owner_o), 64'(2'b10));
    clr_cnt();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t3_busy_mid", 64'(busy_o), 64'(1));
    cyc(1'b0, 1'b1, 1'b0);
    chk("t3_d_acks", 64'(n_da), 64'(4));
    chk("t3_idle", 64'(busy_o), 64'(0));
    cyc(1'b0, 1'b1, 1'b0);
    chk("t3_spurious", 64'(n_da + n_ia), 64'(4));
    // I burst aborted by an error on beat 2
    set_i(34'h600, WRAP, 1'b0, 1'b0);
    tick();
    chk("t4_owner", 64'(owner_o), 64'(2'b01));
    clr_cnt();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t4_i_err", 64'(n_ie), 64'(1));
    chk("t4_i_acks", 64'(n_ia), 64'(1));
    chk("t4_idle", 64'(busy_o), 64'(0));
    set_i(34'h700, SINGLE, 1'b0, 1'b0);
    tick();
    cyc(1'b1, 1'b1, 1'b0);
    chk("t4_single_after_err", 64'(busy_o), 64'(0));
    // locked D write holds the bus against a pending I request
    set_d(34'h300, SINGLE, 1'b1, 1'b1);
    set_i(34'h500, SINGLE, 1'b0, 1'b0);
    tick();
    chk("t5_owner_d", 64'(owner_o), 64'(2'b10));
    chk("t5_we", 64'(biu_we_o), 64'(1));
    chk("t5_lock", 64'(biu_lock_o), 64'(1));
    clr_cnt();
    cyc(1'b1, 1'b1, 1'b0);
    chk("t5_locked_busy", 64'(busy_o), 64'(1));
    chk("t5_locked_owner", 64'(owner_o), 64'(2'b10));
    chk("t5_locked_nostb", 64'(biu_stb_o), 64'(0));
    cyc(1'b0, 1'b1, 1'b0);
    chk("t5_locked_ack_ignored", 64'(n_da + n_ia), 64'(1));
    chk("t5_still_d", 64'(owner_o), 64'(2'b10));
    set_d(34'h340, SINGLE, 1'b1, 1'b1);
    tick();
    chk("t5_d_again", 64'(owner_o), 64'(2'b10));
    chk("t5_d_again_adr", 64'(biu_adr_o), 64'(34'h340));
    cyc(1'b1, 1'b1, 1'b0);
    d_lock_i = 1'b0;
    tick();
    chk("t5_unlock_idle", 64'(owner_o), 64'(0));
    tick();
    chk("t5_i_granted", 64'(owner_o), 64'(2'b01));
    chk("t5_i_adr", 64'(biu_adr_o), 64'(34'h500));
    cyc(1'b1, 1'b1, 1'b0);
    // reset during the third beat of a D burst
    set_d(34'h900, INCR, 1'b0, 1'b0);
    tick();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    biu_ack_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("t6_no_ack", 64'(d_ack_o), 64'(0));
    chk("t6_busy", 64'(busy_o), 64'(0));
    chk("t6_owner", 64'(owner_o), 64'(0));
    chk("t6_stb", 64'(biu_stb_o), 64'(0));
    chk("t6_adr", 64'(biu_adr_o), 64'(0));
    biu_ack_i = 1'b0; i_req_i = 1'b0; d_req_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    set_i(34'hA00, SINGLE, 1'b0, 1'b0);
    set_d(34'hB00, SINGLE, 1'b0, 1'b0);
    tick();
    chk("t6_tie_d", 64'(owner_o), 64'(2'b10));
    cyc(1'b1, 1'b1, 1'b0);
    tick();
    chk("t6_then_i", 64'(owner_o), 64'(2'b01));
    cyc(1'b1, 1'b1, 1'b0);
    // table-driven arbitration sequence from reset
    do_reset();
    for (int k = 0; k < 8; k++) begin
      i_req_i = 1'b0;
      d_req_i = 1'b0;
      if (tv[k].i_req) set_i(34'h1000 + 34'(k * 16), tv[k].i_ty, 1'b0, 1'b0);
      if (tv[k].d_req) set_d(34'h2000 + 34'(k * 16), tv[k].d_ty, 1'b0, 1'b0);
      tick();
      chk($sformatf("tv%0d_owner", k), 64'(owner_o), 64'(tv[k].exp_own));
      chk($sformatf("tv%0d_adr", k), 64'(biu_adr_o), 64'(tv[k].exp_adr));
      serve(tv[k].exp_beats, 0);
      post_chk($sformatf("tv%0d", k), tv[k].exp_own[1], tv[k].exp_beats, 0);
    end
    // randomized traffic against a transaction-level model
    do_reset();
    last_d = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!i_req_i && $urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 2);
        set_i(34'($urandom) & 34'h3_FFFF_FFFC, r == 0 ? SINGLE : r == 1 ? INCR : WRAP, 1'($urandom_range(0, 1)), 1'b0);
      end
      if (!d_req_i && $urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 2);
        set_d(34'($urandom) & 34'h3_FFFF_FFFC, r == 0 ? SINGLE : r == 1 ? INCR : WRAP, 1'($urandom_range(0, 1)), 1'b0);
      end
      if (!i_req_i && !d_req_i) set_i(34'h44, SINGLE, 1'b0, 1'b0);
      w = (i_req_i && d_req_i) ? !last_d : d_req_i;
      ea = w ? d_adr_i : i_adr_i;
      ety = w ? d_type_i : i_type_i;
      ewe = w ? d_we_i : i_we_i;
      ed = w ? d_d_i : i_d_i;
      beats = ety == SINGLE ? 1 : BL;
      err_at = (beats > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(2, beats) : 0;
      chk("rnd_no_comb_stb", 64'(biu_stb_o), 64'(0));
      tick();
      chk("rnd_owner", 64'(owner_o), w ? 64'(2'b10) : 64'(2'b01));
      chk("rnd_adr", 64'(biu_adr_o), 64'(ea));
      chk("rnd_type", 64'(biu_type_o), 64'(ety));
      chk("rnd_we", 64'(biu_we_o), 64'(ewe));
      chk("rnd_d", 64'(biu_d_o), 64'(ed));
      last_d = w;
      serve(beats, err_at);
      post_chk("rnd", w, err_at != 0 ? err_at - 1 : beats, err_at != 0 ? 1 : 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
